// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and status pulses between the host logic
// and the PS/2 transmitter.
//   Handshake: a byte moves when tx_valid and tx_ready are both high on a
//   rising clk edge; tx_data must be stable while tx_valid is high, and
//   tx_ready is only high while the transmitter is idle.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, ack_err, timeout
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, ack_err, timeout
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter. Inhibits the bus, drives a
// start bit, shifts out 8 data bits LSB first plus odd parity on device clock
// falls, releases for the stop bit and samples the device ACK.
// Optional build macro PS2_TX_TIMEOUT_EN adds a watchdog on the device clock.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic              clk,
  input  logic              rst_n,
  ps2_host_tx_if.slave      bus,
  input  logic              ps2_clk_in,
  input  logic              ps2_data_in,
  output logic              ps2_clk_oe,
  output logic              ps2_data_oe,
  output logic [2:0]        state_dbg
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_DATA    = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);

  logic [2:0]    state;
  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          sync_clk_q;
  logic          sync_clk;
  logic          sync_data;
  logic          fall;
  logic [8:0]    frame;      // {parity, data}, shifted out from bit 0
  logic [3:0]    bit_cnt;    // device clock falls seen since the start bit
  logic [IW-1:0] inh_cnt;
  logic          ack_ok;
  logic          wd_expire;

  assign sync_clk  = clk_sync[1];
  assign sync_data = data_sync[1];
  assign fall      = sync_clk_q & ~sync_clk;

  assign state_dbg    = state;
  assign bus.tx_ready = (state == S_IDLE);
  assign bus.busy     = (state != S_IDLE);
  assign bus.ack_err  = (state == S_ACK) && fall && sync_data;
  assign bus.done     = (state == S_WAIT) && sync_clk && sync_data && ack_ok;

  // Two-flop synchronizers for the asynchronous PS/2 lines plus edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      sync_clk_q <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk_in};
      data_sync  <= {data_sync[0], ps2_data_in};
      sync_clk_q <= sync_clk;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_cnt;
  logic          wd_run;

  assign wd_run      = (state == S_REQ) || (state == S_DATA) ||
                       (state == S_ACK) || (state == S_WAIT);
  assign wd_expire   = wd_run && !fall && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
  assign bus.timeout = wd_expire;

  // Watchdog: counts clk cycles since the last device clock fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (!wd_run || fall) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // Frame sequencer: owns the state and both registered open-drain enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      frame       <= '0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      ack_ok      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.tx_valid) begin
            frame      <= {~^bus.tx_data, bus.tx_data};
            ack_ok     <= 1'b0;
            inh_cnt    <= '0;
            ps2_clk_oe <= 1'b1;
            state      <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          // Clock release and start bit happen on the same edge.
          if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            bit_cnt     <= '0;
            state       <= S_REQ;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        S_REQ, S_DATA: begin
          if (fall) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd9) begin
              ps2_data_oe <= 1'b0;
              state       <= S_ACK;
            end else begin
              ps2_data_oe <= ~frame[0];
              frame       <= frame >> 1;
              state       <= S_DATA;
            end
          end
        end
        S_ACK: begin
          if (fall) begin
            ack_ok <= ~sync_data;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (sync_clk && sync_data) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (wd_expire) begin
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        state       <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives command bytes into ps2_host_tx against a behavioural
// PS/2 keyboard model on open-drain wires; a scoreboard compares the frame the
// keyboard read with the frame expected from the byte's value.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 400;
  localparam int HP  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_host_tx_if bus();

  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       clk_oe;
  logic       data_oe;
  logic [2:0] state_dbg;
  wire        ps2_clk_line  = dev_clk & ~clk_oe;
  wire        ps2_data_line = dev_data & ~data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (clk_oe),
    .ps2_data_oe (data_oe),
    .state_dbg   (state_dbg)
  );

  int          checks = 0;
  int          errors = 0;
  int          frames_done = 0;
  int          n_sent = 0;
  logic [11:0] exp_q[$];
  logic [11:0] dev_obs = '0;   // {ack_err, stop, parity, data, start}
  logic [11:0] obs;
  logic [11:0] exp_w;
  int          inh_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: what a keyboard reads for byte d, and whether it signals an error.
  function automatic logic [11:0] model(input logic [7:0] d, input bit ack);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {~ack, 1'b1, par, d, 1'b0};
  endfunction

  task automatic send(input logic [7:0] d, input bit ack, input bit push);
    int budget;
    budget = 0;
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    check("accept_ready", bus.tx_ready, 1);
    @(posedge clk);
    if (push) begin
      exp_q.push_back(model(d, ack));
      n_sent++;
    end
    #1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
  endtask

  // Keyboard: waits for the start bit, clocks up to stop_after falls and
  // reads the data line on every rising edge.
  task automatic dev_run(input bit ack, input int stop_after);
    int         budget;
    logic [9:0] bits;
    logic       start;
    budget = 0;
    bits   = '0;
    while (!(data_oe && !clk_oe) && budget < INH + 200) begin
      @(negedge clk);
      budget++;
    end
    check("request_seen", {31'd0, data_oe && !clk_oe}, 1);
    if (data_oe && !clk_oe) begin
      repeat (5) @(negedge clk);
      start = ps2_data_line;
      for (int k = 1; k <= 11; k++) begin
        if (k > stop_after) break;
        if (k == 11 && ack) begin
          dev_data = 1'b0;
          repeat (2) @(negedge clk);
        end
        dev_clk = 1'b0;
        repeat (HP) @(negedge clk);
        dev_clk = 1'b1;
        if (k <= 10) bits[k-1] = ps2_data_line;
        if (k == 10) dev_obs = {1'b0, bits[9], bits[8], bits[7:0], start};
        repeat (HP) @(negedge clk);
      end
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (bus.busy && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("back_to_idle", bus.busy, 0);
    repeat (20) @(negedge clk);
    check("stay_idle", bus.busy, 0);
  endtask

  task automatic do_frame(input logic [7:0] d, input bit ack, input bit poke);
    fork
      send(d, ack, 1'b1);
      dev_run(ack, 11);
      if (poke) begin
        repeat (INH + 40) @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h5A;
        repeat (3) @(negedge clk);
        bus.tx_valid = 1'b0;
      end
    join
    wait_idle();
  endtask

  // Monitor: scoreboard on done/ack_err, line-sharing and inhibit length checks.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        inh_run = 0;
      end else begin
        if (bus.done || bus.ack_err) begin
          obs     = dev_obs;
          obs[11] = bus.ack_err;
          frames_done++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse actual=%0h required=none", obs);
          end else begin
            exp_w = exp_q.pop_front();
            check("frame", obs, exp_w);
          end
        end
`ifndef PS2_TX_TIMEOUT_EN
        if (bus.timeout) begin
          checks++;
          errors++;
          $display("FAIL timeout_without_watchdog actual=1 required=0");
        end
`endif
        if (clk_oe && data_oe) begin
          checks++;
          errors++;
          $display("FAIL both_oe actual=11 required=not_both");
        end
        if (clk_oe) begin
          inh_run++;
        end else if (inh_run > 0) begin
          check("inhibit_len", inh_run, INH);
          check("start_after_inhibit", data_oe, 1);
          inh_run = 0;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int budget;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hED;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", bus.tx_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_clk_oe", clk_oe, 0);
    check("rst_data_oe", data_oe, 0);
    check("rst_pulses", {bus.done, bus.ack_err, bus.timeout}, 0);
    bus.tx_valid = 1'b0;
    rst_n        = 1'b1;
    repeat (5) @(negedge clk);
    check("no_accept_in_reset", bus.busy, 0);

    // Directed bytes, then an ACK failure, then a busy-time request.
    do_frame(8'hED, 1'b1, 1'b0);
    do_frame(8'h00, 1'b1, 1'b0);
    do_frame(8'h01, 1'b1, 1'b0);
    do_frame(8'hFF, 1'b0, 1'b0);
    do_frame(8'h96, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      do_frame(8'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
    end

    // Device clock stops after fall #4 (bit 3 of 0xF0 is 0, so data is pulled low).
    fork
      send(8'hF0, 1'b1, 1'b0);
      dev_run(1'b1, 4);
    join
`ifdef PS2_TX_TIMEOUT_EN
    budget = 0;
    while (!bus.timeout && budget < TMO + 100) begin
      @(negedge clk);
      budget++;
    end
    check("timeout_pulse", bus.timeout, 1);
    check("timeout_latency", {31'd0, (budget >= TMO - 2*HP - 6) && (budget <= TMO - 2*HP + 10)}, 1);
    @(negedge clk);
    check("timeout_ready", bus.tx_ready, 1);
    check("timeout_oe", {clk_oe, data_oe}, 0);
    check("timeout_single", bus.timeout, 0);
`else
    repeat (2 * TMO) @(negedge clk);
    check("hang_busy", bus.busy, 1);
    check("hang_data_oe", data_oe, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("hang_reset_oe", {clk_oe, data_oe}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
`endif

    // Reset during INHIBIT releases the clock line at once.
    send(8'h3C, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    check("inhibit_active", clk_oe, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midframe_reset_oe", {clk_oe, data_oe}, 0);
    check("midframe_reset_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("after_reset_ready", bus.tx_ready, 1);

    do_frame(8'($urandom), 1'b1, 1'b0);

    repeat (10) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("frame_count", frames_done, n_sent);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
